dma_stream_ctrl: RTL and testbench



---
 rtl/dma_stream_ctrl.sv | 178 +++++++++++++++++
 tb/tb_dma_stream_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/dma_stream_ctrl.sv
// dma_stream_ctrl: user-side controller for a streaming DMA engine.
// Launches one read and one write stream of the same length, adds a
// per-lane constant to every 32-bit lane of each popped cacheline and
// pushes the result into the write stream, then reports completion.
module dma_stream_ctrl #(
  parameter int ADDR_WIDTH = 42,
  parameter int DATA_WIDTH = 512
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  go,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [ADDR_WIDTH:0]   size,
  input  logic [31:0]           add_value,
  output logic                  done,
  output logic                  busy,
  output logic [ADDR_WIDTH:0]   wr_count,
  output logic                  dma_rd_go,
  output logic [ADDR_WIDTH-1:0] dma_rd_addr,
  output logic [ADDR_WIDTH:0]   dma_rd_size,
  output logic                  dma_rd_en,
  output logic                  dma_wr_go,
  output logic [ADDR_WIDTH-1:0] dma_wr_addr,
  output logic                  dma_wr_en,
  output logic [DATA_WIDTH-1:0] dma_wr_data,
  input  logic [DATA_WIDTH-1:0] dma_rd_data,
  input  logic                  dma_empty,
  input  logic                  dma_rd_done,
  input  logic                  dma_full,
  input  logic                  dma_wr_done
);

  localparam int LANES = DATA_WIDTH / 32;
  localparam logic [ADDR_WIDTH:0] CNT_ZERO = {(ADDR_WIDTH+1){1'b0}};
  localparam logic [ADDR_WIDTH:0] CNT_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_XFER  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  // Independent 32-bit adds per lane; carries never cross lane boundaries.
  function automatic logic [DATA_WIDTH-1:0] add_lanes(
    input logic [DATA_WIDTH-1:0] data,
    input logic [31:0]           addend
  );
    logic [DATA_WIDTH-1:0] res;
    res = {DATA_WIDTH{1'b0}};
    for (int i = 0; i < LANES; i++) begin
      res[32*i +: 32] = data[32*i +: 32] + addend;
    end
    return res;
  endfunction

  state_t                state_r, next_state_s;
  logic                  accept_go_s, rd_en_s, wr_acc_s;
  logic [ADDR_WIDTH-1:0] rd_addr_r, wr_addr_r;
  logic [ADDR_WIDTH:0]   size_r, rd_cnt_r, wr_count_r;
  logic [31:0]           add_r;
  logic [DATA_WIDTH-1:0] out_data_r;
  logic                  out_valid_r, done_r, busy_r, go_r;

  // Next-state decode plus the combinational pop/accept handshakes.
  always_comb begin
    next_state_s = state_r;
    accept_go_s  = 1'b0;
    rd_en_s      = 1'b0;
    wr_acc_s     = 1'b0;
    case (state_r)
      S_IDLE, S_DONE: begin
        if (go) begin
          accept_go_s = 1'b1;
          if (size != CNT_ZERO) begin
            next_state_s = S_START;
          end else begin
            next_state_s = S_DONE;
          end
        end else begin
          next_state_s = state_r;
        end
      end
      S_START: begin
        next_state_s = S_XFER;
      end
      S_XFER: begin
        rd_en_s  = !dma_empty && (rd_cnt_r < size_r) && (!out_valid_r || !dma_full);
        wr_acc_s = out_valid_r && !dma_full;
        if ((wr_count_r == size_r) && !out_valid_r) begin
          next_state_s = S_DRAIN;
        end else begin
          next_state_s = S_XFER;
        end
      end
      S_DRAIN: begin
        if (dma_rd_done && dma_wr_done) begin
          next_state_s = S_DONE;
        end else begin
          next_state_s = S_DRAIN;
        end
      end
      default: begin
        next_state_s = S_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Latched job parameters, counters, output register and status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_addr_r   <= {ADDR_WIDTH{1'b0}};
      wr_addr_r   <= {ADDR_WIDTH{1'b0}};
      size_r      <= CNT_ZERO;
      add_r       <= 32'd0;
      rd_cnt_r    <= CNT_ZERO;
      wr_count_r  <= CNT_ZERO;
      out_data_r  <= {DATA_WIDTH{1'b0}};
      out_valid_r <= 1'b0;
      done_r      <= 1'b0;
      busy_r      <= 1'b0;
      go_r        <= 1'b0;
    end else begin
      if (accept_go_s) begin
        rd_addr_r   <= rd_addr;
        wr_addr_r   <= wr_addr;
        size_r      <= size;
        add_r       <= add_value;
        rd_cnt_r    <= CNT_ZERO;
        wr_count_r  <= CNT_ZERO;
        out_valid_r <= 1'b0;
      end else begin
        if (rd_en_s) begin
          out_data_r  <= add_lanes(dma_rd_data, add_r);
          rd_cnt_r    <= rd_cnt_r + CNT_ONE;
          out_valid_r <= 1'b1;
        end else if (wr_acc_s) begin
          out_valid_r <= 1'b0;
        end else begin
          out_valid_r <= out_valid_r;
        end
        if (wr_acc_s) begin
          wr_count_r <= wr_count_r + CNT_ONE;
        end else begin
          wr_count_r <= wr_count_r;
        end
      end
      done_r <= (next_state_s == S_DONE);
      busy_r <= (next_state_s == S_START) || (next_state_s == S_XFER) ||
                (next_state_s == S_DRAIN);
      go_r   <= (next_state_s == S_START);
    end
  end

  assign done        = done_r;
  assign busy        = busy_r;
  assign wr_count    = wr_count_r;
  assign dma_rd_go   = go_r;
  assign dma_wr_go   = go_r;
  assign dma_rd_addr = rd_addr_r;
  assign dma_wr_addr = wr_addr_r;
  assign dma_rd_size = size_r;
  assign dma_rd_en   = rd_en_s;
  assign dma_wr_en   = out_valid_r;
  assign dma_wr_data = out_data_r;

endmodule

// File: tb/tb_dma_stream_ctrl.sv
// Testbench for dma_stream_ctrl: a small DMA engine model (show-ahead read
// FIFO, write sink with full back-pressure, delayed done flags) driven
// from a table of transfer vectors plus hand-written corner sequences.
module tb_dma_stream_ctrl;

  localparam int AW = 42;
  localparam int DW = 512;

  logic          clk, rst, go;
  logic [AW-1:0] rd_addr, wr_addr;
  logic [AW:0]   size;
  logic [31:0]   add_value;
  logic          done, busy;
  logic [AW:0]   wr_count;
  logic          dma_rd_go, dma_rd_en, dma_wr_go, dma_wr_en;
  logic [AW-1:0] dma_rd_addr, dma_wr_addr;
  logic [AW:0]   dma_rd_size;
  logic [DW-1:0] dma_wr_data, dma_rd_data;
  logic          dma_empty, dma_rd_done, dma_full, dma_wr_done;

  dma_stream_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .go(go), .rd_addr(rd_addr), .wr_addr(wr_addr),
    .size(size), .add_value(add_value), .done(done), .busy(busy),
    .wr_count(wr_count), .dma_rd_go(dma_rd_go), .dma_rd_addr(dma_rd_addr),
    .dma_rd_size(dma_rd_size), .dma_rd_en(dma_rd_en), .dma_wr_go(dma_wr_go),
    .dma_wr_addr(dma_wr_addr), .dma_wr_en(dma_wr_en), .dma_wr_data(dma_wr_data),
    .dma_rd_data(dma_rd_data), .dma_empty(dma_empty), .dma_rd_done(dma_rd_done),
    .dma_full(dma_full), .dma_wr_done(dma_wr_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          size;
    logic [31:0] add;
    logic [31:0] in_lane;
    logic [31:0] exp_lane;
    bit          full_mode;
    bit          empty_mode;
    int          go_again;
    int          rst_at;
    bit          b2b;
    int          exp_wrc;
  } vec_t;

  vec_t tbl[7];
  int errors = 0;
  int checks = 0;

  int cyc, m_rd_ptr, m_wr_idx, m_last_w, viol, rd_go_cnt, rden_first, rden_last;
  bit dones_prev, dones_prev2;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_wide(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Cacheline i: lane j = base + (i<<16) + (j<<8).
  function automatic logic [DW-1:0] mk_line(input logic [31:0] base, input int i);
    logic [DW-1:0] l;
    for (int j = 0; j < DW/32; j++) begin
      l[32*j +: 32] = base + 32'(i << 16) + 32'(j << 8);
    end
    return l;
  endfunction

  // One clock cycle of the engine model; entered and left at posedge+1.
  task automatic step(input vec_t v);
    bit dn;
    dma_empty   = (m_rd_ptr >= v.size) || (v.empty_mode && (cyc % 2 == 1));
    dma_rd_data = mk_line(v.in_lane, m_rd_ptr);
    dma_full    = v.full_mode && (cyc % 3 != 0);
    dn          = (m_wr_idx >= v.size) && (cyc >= m_last_w + 3);
    dma_rd_done = dn;
    dma_wr_done = dn;
    go          = (v.go_again > 0) && (cyc == v.go_again);
    if (go) size = 43'd9;
    #3;
    if (dma_rd_go) rd_go_cnt++;
    if (dma_rd_en && dma_wr_en && dma_full) viol++;
    if (dma_rd_en && dma_empty) viol++;
    if (dma_wr_en && !dma_full) begin
      if (m_wr_idx < v.size) chk_wide("wr_data", dma_wr_data, mk_line(v.exp_lane, m_wr_idx));
      else viol++;
      m_wr_idx++;
      m_last_w = cyc;
    end
    if (dma_rd_en) begin
      if (rden_first < 0) rden_first = cyc;
      rden_last = cyc;
      m_rd_ptr++;
    end
    @(posedge clk); #1;
    go = 1'b0;
    cyc++;
    dones_prev2 = dones_prev;
    dones_prev  = dn;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_wr_count"}, 64'(wr_count), 64'd0);
    chk({tag, "_gos"}, 64'({dma_rd_go, dma_wr_go}), 64'd0);
    chk({tag, "_ens"}, 64'({dma_rd_en, dma_wr_en}), 64'd0);
    chk({tag, "_addrs"}, 64'(dma_rd_addr | dma_wr_addr), 64'd0);
    chk({tag, "_rd_size"}, 64'(dma_rd_size), 64'd0);
  endtask

  task automatic run_xfer(input vec_t v, input int idx);
    bit finished;
    logic [AW-1:0] ra, wa;
    ra = 42'h100 + 42'(idx);
    wa = 42'h3_0000_0000 + 42'(idx);
    cyc = 0; m_rd_ptr = 0; m_wr_idx = 0; m_last_w = 0; viol = 0;
    rd_go_cnt = 0; rden_first = -1; rden_last = -1;
    dones_prev = 1'b0; dones_prev2 = 1'b0; finished = 1'b0;
    dma_empty = 1'b0; dma_full = 1'b0;
    dma_rd_done = 1'b1; dma_wr_done = 1'b1;   // stale high from the last job
    go = 1'b1; size = 43'(v.size); rd_addr = ra; wr_addr = wa; add_value = v.add;
    @(posedge clk); #1;
    go = 1'b0;
    chk("start_gos", 64'({dma_rd_go, dma_wr_go}), 64'h3);
    chk("start_addrs", {dma_rd_addr[31:0], dma_wr_addr[31:0]}, {ra[31:0], wa[31:0]});
    chk("start_rd_size", 64'(dma_rd_size), 64'(v.size));
    chk("start_no_en", 64'({dma_rd_en, dma_wr_en}), 64'd0);
    chk("start_done_busy", 64'({done, busy}), 64'h1);
    for (int k = 0; k < 300 && !finished; k++) begin
      step(v);
      if (v.rst_at > 0 && m_wr_idx == v.rst_at) begin
        chk("pre_rst_wr_count", 64'(wr_count), 64'(v.rst_at));
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk_reset_vals("mid_rst");
        return;
      end
      if (done) begin
        chk("done_timing", 64'({dones_prev2, dones_prev}), 64'h1);
        finished = 1'b1;
      end
    end
    chk("done_seen", 64'(finished), 64'd1);
    chk("wr_count", 64'(wr_count), 64'(v.exp_wrc));
    chk("busy_after", 64'(busy), 64'd0);
    if (v.b2b) chk("rd_en_b2b", 64'(rden_last - rden_first + 1), 64'(v.size));
    step(v);
    step(v);
    chk("done_hold", 64'(done), 64'd1);
    chk("lines_read", 64'(m_rd_ptr), 64'(v.size));
    chk("lines_written", 64'(m_wr_idx), 64'(v.size));
    chk("protocol_viol", 64'(viol), 64'd0);
    chk("rd_go_pulses", 64'(rd_go_cnt), 64'd1);
  endtask

  initial begin
    //            size add           in_lane       exp_lane      full empty goag rst b2b wrc
    tbl[0] = '{4, 32'h1,        32'h10,       32'h11,       1'b0, 1'b0, 0, 0, 1'b1, 4};
    tbl[1] = '{3, 32'hFFFF_FFFF, 32'h1,       32'h0,        1'b0, 1'b0, 0, 0, 1'b1, 3};
    tbl[2] = '{8, 32'h100,      32'hA000_0000, 32'hA000_0100, 1'b1, 1'b0, 0, 0, 1'b0, 8};
    tbl[3] = '{5, 32'h7,        32'h20,       32'h27,       1'b0, 1'b0, 3, 0, 1'b1, 5};
    tbl[4] = '{6, 32'h2,        32'h30,       32'h32,       1'b0, 1'b1, 0, 2, 1'b0, 2};
    tbl[5] = '{2, 32'h3,        32'h40,       32'h43,       1'b0, 1'b0, 0, 0, 1'b1, 2};
    tbl[6] = '{4, 32'h0101_0101, 32'hFFFF_FFFF, 32'h0101_0100, 1'b1, 1'b1, 0, 0, 1'b0, 4};

    rst = 1'b1; go = 1'b0; size = '0; rd_addr = '0; wr_addr = '0; add_value = 32'd0;
    dma_rd_data = '0; dma_empty = 1'b0; dma_full = 1'b0;
    dma_rd_done = 1'b0; dma_wr_done = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk_reset_vals("reset");

    // Zero-length job: straight to DONE, no stream launch.
    go = 1'b1; size = 43'd0; rd_addr = 42'h55; wr_addr = 42'h66; add_value = 32'h9;
    @(posedge clk); #1;
    go = 1'b0;
    chk("size0_done", 64'(done), 64'd1);
    chk("size0_gos", 64'({dma_rd_go, dma_wr_go}), 64'd0);
    chk("size0_busy", 64'(busy), 64'd0);
    @(posedge clk); #1;
    chk("size0_done_hold", 64'(done), 64'd1);
    chk("size0_gos_later", 64'({dma_rd_go, dma_wr_go}), 64'd0);

    for (int i = 0; i < 7; i++) begin
      run_xfer(tbl[i], i);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
